ws2812_strand_driver: RTL and testbench



---
 rtl/led_pkg.sv | 30 +++
 rtl/ws2812_bit_timer.sv | 69 ++++++
 rtl/ws2812_strand_driver.sv | 153 +++++++++++++++
 tb/tb_ws2812_strand_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and default timing for the WS2812 strand driver.
// Default timings assume a 100 MHz clk_in.
package led_pkg;

    typedef enum logic [1:0] {
        LATCH = 2'd0,
        WAIT  = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } led_state_e;

    localparam int NUM_LEDS_DEF     = 20;
    localparam int COLOR_WIDTH_DEF  = 8;
    localparam int BITS_PER_LED     = 3 * COLOR_WIDTH_DEF;
    localparam int T0H_CYCLES_DEF   = 40;
    localparam int T0L_CYCLES_DEF   = 85;
    localparam int T1H_CYCLES_DEF   = 80;
    localparam int T1L_CYCLES_DEF   = 45;
    localparam int RESET_CYCLES_DEF = 5000;

    // Next LED index, wrapping from limit-1 back to zero.
    function automatic int wrap_inc(input int idx, input int limit);
        if (idx + 32'sd1 >= limit) begin
            return 32'sd0;
        end else begin
            return idx + 32'sd1;
        end
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Sequences the high and low phases of one WS2812 bit; a start issued on the
// cycle bit_done is high chains the next bit with no idle cycle.
module ws2812_bit_timer
    import led_pkg::*;
#(
    parameter int T0H_CYCLES = T0H_CYCLES_DEF,
    parameter int T0L_CYCLES = T0L_CYCLES_DEF,
    parameter int T1H_CYCLES = T1H_CYCLES_DEF,
    parameter int T1L_CYCLES = T1L_CYCLES_DEF
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic start,
    input  logic bit_value,
    output logic strand_out,
    output logic high_done,
    output logic bit_done
);

    localparam int MaxHigh = (T1H_CYCLES > T0H_CYCLES) ? T1H_CYCLES : T0H_CYCLES;
    localparam int MaxLow  = (T1L_CYCLES > T0L_CYCLES) ? T1L_CYCLES : T0L_CYCLES;
    localparam int MaxT    = (MaxHigh > MaxLow) ? MaxHigh : MaxLow;
    localparam int TW      = (MaxT > 1) ? $clog2(MaxT) : 1;

    logic          high_r;
    logic          low_r;
    logic          bit_r;
    logic [TW-1:0] timer_r;
    logic          out_r;

    // Phase sequencer: high phase then low phase, lengths picked by the latched bit.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            high_r  <= 1'b0;
            low_r   <= 1'b0;
            bit_r   <= 1'b0;
            timer_r <= '0;
            out_r   <= 1'b0;
        end else if (start) begin
            high_r  <= 1'b1;
            low_r   <= 1'b0;
            bit_r   <= bit_value;
            timer_r <= bit_value ? TW'(T1H_CYCLES - 1) : TW'(T0H_CYCLES - 1);
            out_r   <= 1'b1;
        end else if (high_r) begin
            if (timer_r == '0) begin
                high_r  <= 1'b0;
                low_r   <= 1'b1;
                timer_r <= bit_r ? TW'(T1L_CYCLES - 1) : TW'(T0L_CYCLES - 1);
                out_r   <= 1'b0;
            end else begin
                timer_r <= timer_r - TW'(1);
            end
        end else if (low_r) begin
            if (timer_r == '0) begin
                low_r <= 1'b0;
            end else begin
                timer_r <= timer_r - TW'(1);
            end
        end else begin
            out_r <= 1'b0;
        end
    end

    assign strand_out = out_r;
    assign high_done  = high_r && (timer_r == '0);
    assign bit_done   = low_r && (timer_r == '0);

endmodule

// File: rtl/ws2812_strand_driver.sv
// Walks the strand LED by LED, prefetching each colour into a one-entry buffer
// and serialising it GRB/MSB-first, with a latch gap between frames.
module ws2812_strand_driver
    import led_pkg::*;
#(
    parameter  int NUM_LEDS     = NUM_LEDS_DEF,
    parameter  int COLOR_WIDTH  = COLOR_WIDTH_DEF,
    parameter  int T0H_CYCLES   = T0H_CYCLES_DEF,
    parameter  int T0L_CYCLES   = T0L_CYCLES_DEF,
    parameter  int T1H_CYCLES   = T1H_CYCLES_DEF,
    parameter  int T1L_CYCLES   = T1L_CYCLES_DEF,
    parameter  int RESET_CYCLES = RESET_CYCLES_DEF,
    localparam int CounterWidth = $clog2(NUM_LEDS)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [COLOR_WIDTH-1:0]  red_in,
    input  logic [COLOR_WIDTH-1:0]  green_in,
    input  logic [COLOR_WIDTH-1:0]  blue_in,
    input  logic                    color_valid,
    output logic [CounterWidth-1:0] next_led_request,
    output logic                    strand_out,
    output logic                    frame_done
);

    localparam int Bits    = 3 * COLOR_WIDTH;
    localparam int BitCntW = $clog2(Bits);
    localparam int LatchW  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CounterWidth-1:0] LastLed = CounterWidth'(NUM_LEDS - 1);
    localparam logic [BitCntW-1:0]      BitTop  = BitCntW'(Bits - 1);

    led_state_e              state_r;
    logic [Bits-1:0]         buf_r;
    logic                    buf_valid_r;
    logic [Bits-1:0]         shift_r;
    logic [BitCntW-1:0]      bit_cnt_r;
    logic [CounterWidth-1:0] led_idx_r;
    logic [LatchW-1:0]       latch_cnt_r;
    logic                    frame_done_r;
    logic [CounterWidth-1:0] request_r;

    logic high_done_s;
    logic bit_done_s;
    logic last_bit_s;
    logic load_s;
    logic shift_next_s;
    logic capture_s;
    logic start_s;
    logic start_bit_s;

    assign last_bit_s   = (state_r == LOW) && bit_done_s && (bit_cnt_r == '0);
    assign load_s       = buf_valid_r && ((state_r == WAIT) ||
                                          (last_bit_s && (led_idx_r != LastLed)));
    assign shift_next_s = (state_r == LOW) && bit_done_s && (bit_cnt_r != '0);
    assign capture_s    = color_valid && !buf_valid_r;
    assign start_s      = load_s || shift_next_s;
    assign start_bit_s  = load_s ? buf_r[Bits-1] : shift_r[Bits-2];

    // Prefetch buffer; the request index only advances when the buffer is consumed.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            buf_r       <= '0;
            buf_valid_r <= 1'b0;
            request_r   <= '0;
        end else if (load_s) begin
            buf_valid_r <= 1'b0;
            request_r   <= CounterWidth'(wrap_inc(int'(request_r), NUM_LEDS));
        end else if (capture_s) begin
            buf_r       <= {green_in, red_in, blue_in};
            buf_valid_r <= 1'b1;
        end else begin
            buf_valid_r <= buf_valid_r;
        end
    end

    // Frame FSM: latch gap, wait for data, then bit-by-bit through each LED.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r      <= LATCH;
            latch_cnt_r  <= LatchW'(RESET_CYCLES - 1);
            frame_done_r <= 1'b0;
            shift_r      <= '0;
            bit_cnt_r    <= '0;
            led_idx_r    <= '0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                LATCH: begin
                    if (latch_cnt_r == '0) begin
                        frame_done_r <= 1'b1;
                        state_r      <= WAIT;
                    end else begin
                        latch_cnt_r <= latch_cnt_r - LatchW'(1);
                    end
                end
                WAIT: begin
                    if (load_s) begin
                        shift_r   <= buf_r;
                        bit_cnt_r <= BitTop;
                        state_r   <= HIGH;
                    end
                end
                HIGH: begin
                    if (high_done_s) begin
                        state_r <= LOW;
                    end
                end
                LOW: begin
                    if (shift_next_s) begin
                        shift_r   <= {shift_r[Bits-2:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r - BitCntW'(1);
                        state_r   <= HIGH;
                    end else if (last_bit_s && (led_idx_r == LastLed)) begin
                        led_idx_r   <= '0;
                        latch_cnt_r <= LatchW'(RESET_CYCLES - 1);
                        state_r     <= LATCH;
                    end else if (last_bit_s) begin
                        led_idx_r <= led_idx_r + CounterWidth'(1);
                        if (buf_valid_r) begin
                            shift_r   <= buf_r;
                            bit_cnt_r <= BitTop;
                            state_r   <= HIGH;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                default: begin
                    state_r <= LATCH;
                end
            endcase
        end
    end

    ws2812_bit_timer #(
        .T0H_CYCLES (T0H_CYCLES),
        .T0L_CYCLES (T0L_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .T1L_CYCLES (T1L_CYCLES)
    ) u_bit_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start      (start_s),
        .bit_value  (start_bit_s),
        .strand_out (strand_out),
        .high_done  (high_done_s),
        .bit_done   (bit_done_s)
    );

    assign frame_done       = frame_done_r;
    assign next_led_request = request_r;

endmodule

// File: tb/tb_ws2812_strand_driver.sv
// Randomised bench: a 1-cycle pattern-stage model feeds colours and queues the
// expected GRB words; a line monitor decodes pulses and checks them in order.
module tb_ws2812_strand_driver;

    localparam int NUM     = 3;
    localparam int CW      = 8;
    localparam int T0H     = 2;
    localparam int T0L     = 4;
    localparam int T1H     = 4;
    localparam int T1L     = 2;
    localparam int RST_CYC = 10;
    localparam int BITS    = 3 * CW;
    localparam int LEAD    = RST_CYC + 1;   // latch gap plus the WAIT cycle carrying frame_done
    localparam int STALL_FRAME = 1;
    localparam int STALL_LEN   = 160;       // longer than one LED, so the line must stretch

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [CW-1:0] red_in = '0;
    logic [CW-1:0] green_in = '0;
    logic [CW-1:0] blue_in = '0;
    logic          color_valid;
    logic [1:0]    next_led_request;
    logic          strand_out;
    logic          frame_done;

    always #5 clk_in = ~clk_in;

    ws2812_strand_driver #(
        .NUM_LEDS     (NUM),
        .COLOR_WIDTH  (CW),
        .T0H_CYCLES   (T0H),
        .T0L_CYCLES   (T0L),
        .T1H_CYCLES   (T1H),
        .T1L_CYCLES   (T1L),
        .RESET_CYCLES (RST_CYC)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .red_in           (red_in),
        .green_in         (green_in),
        .blue_in          (blue_in),
        .color_valid      (color_valid),
        .next_led_request (next_led_request),
        .strand_out       (strand_out),
        .frame_done       (frame_done)
    );

    typedef enum int {K_FIRST, K_FRAME, K_NEXT, K_STALL} gap_e;
    typedef struct {
        logic [BITS-1:0] grb;
        int              led;
        gap_e            kind;
    } item_t;

    item_t exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_cond(input string name, input bit ok, input int act, input int bound);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s: got %0d, bound %0d", name, act, bound);
        end
    endtask

    // ---------------- pattern-stage model ----------------
    int      idx_q = 0;
    int      last_req = 0;
    bit      need_new = 1'b1;
    bit      fixed_used = 1'b0;
    int      frame_no = 0;
    int      stall_left = 0;
    int      age = 0;
    logic [CW-1:0] cur_r, cur_g, cur_b;

    assign color_valid = !rst_in && (stall_left == 0) && (idx_q == int'(next_led_request));

    always @(negedge clk_in) begin
        int    req;
        item_t it;
        if (rst_in) begin
            exp_q.delete();
            need_new   = 1'b1;
            idx_q      = 0;
            last_req   = 0;
            stall_left = 0;
        end else begin
            req = int'(next_led_request);
            if (need_new || req != last_req) begin
                if (!need_new) check("req_seq", req, (last_req + 1) % NUM);
                if (req == 0 && !need_new) frame_no++;
                if (req == 0) it.kind = need_new ? K_FIRST : K_FRAME;
                else if (req == 1 && frame_no == STALL_FRAME) begin
                    it.kind    = K_STALL;
                    stall_left = STALL_LEN;
                end else it.kind = K_NEXT;
                if (!fixed_used) begin
                    cur_r = 8'h00; cur_g = 8'hFF; cur_b = 8'h0F;
                    fixed_used = 1'b1;
                end else begin
                    cur_r = CW'($urandom); cur_g = CW'($urandom); cur_b = CW'($urandom);
                end
                it.grb = {cur_g, cur_r, cur_b};
                it.led = req;
                exp_q.push_back(it);
                age      = 0;
                need_new = 1'b0;
                last_req = req;
            end else begin
                age++;
            end
            if (stall_left > 0) stall_left--;
            idx_q = req;
            // Upstream colour changes after capture must not reach the line.
            if (age == 3 && stall_left == 0) begin
                cur_r = CW'($urandom); cur_g = CW'($urandom); cur_b = CW'($urandom);
            end
            if (stall_left > 0) begin
                red_in = CW'($urandom); green_in = CW'($urandom); blue_in = CW'($urandom);
            end else begin
                red_in = cur_r; green_in = cur_g; blue_in = cur_b;
            end
        end
    end

    // ---------------- line monitor ----------------
    bit    prev_lvl = 1'b0;
    int    high_len = 0;
    int    low_len = 0;
    int    bit_pos = 0;
    bit    have_item = 1'b0;
    item_t cur;
    int    prev_tl = 0;
    int    frames_seen = 0;

    always @(negedge clk_in) begin
        int  base;
        bit  bitv;
        if (rst_in) begin
            prev_lvl  = 1'b0;
            high_len  = 0;
            low_len   = 0;
            bit_pos   = 0;
            have_item = 1'b0;
            prev_tl   = 0;
        end else begin
            if (strand_out) begin
                if (!prev_lvl) begin
                    if (!have_item || bit_pos == BITS) begin
                        if (exp_q.size() == 0) begin
                            check("queue_empty", 1, 0);
                        end else begin
                            cur = exp_q.pop_front();
                            case (cur.kind)
                                K_FIRST: check("lead_gap", low_len, LEAD);
                                K_FRAME: check("frame_gap", low_len, prev_tl + LEAD);
                                K_NEXT:  check("led_gap", low_len, prev_tl);
                                K_STALL: check_cond("stall_gap", low_len > prev_tl, low_len, prev_tl + 1);
                                default: check("kind", 0, 1);
                            endcase
                        end
                        have_item = 1'b1;
                        bit_pos   = 0;
                    end else begin
                        check("bit_low", low_len, prev_tl);
                    end
                    high_len = 0;
                end
                high_len++;
                if (frame_done) check("frame_done_spurious", 1, 0);
            end else begin
                if (prev_lvl) begin
                    check_cond("high_len", high_len == T1H || high_len == T0H, high_len, T0H);
                    bitv = (high_len == T1H);
                    if (bit_pos < BITS) check("data_bit", int'(bitv), int'(cur.grb[BITS-1-bit_pos]));
                    bit_pos++;
                    prev_tl = bitv ? T1L : T0L;
                    low_len = 0;
                end
                low_len++;
                if (!have_item) base = 0;
                else if (bit_pos == BITS && cur.led == NUM - 1) base = prev_tl;
                else base = -1000;
                if (low_len == base + LEAD) begin
                    check("frame_done", int'(frame_done), 1);
                    frames_seen++;
                end else if (frame_done) begin
                    check("frame_done_spurious", 1, 0);
                end
            end
            prev_lvl = strand_out;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit found;
        int target;
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_strand_out", int'(strand_out), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_request", int'(next_led_request), 0);
        rst_in = 1'b0;

        // Run until LED1 bit 5 is in its high phase in a frame after the stall.
        found = 1'b0;
        for (int c = 0; c < 6000 && !found; c++) begin
            @(negedge clk_in);
            #1;
            if (have_item && cur.led == 1 && bit_pos == 5 && strand_out && frame_no >= 2) found = 1'b1;
        end
        check("reset_point_reached", int'(found), 1);

        if (found) begin
            rst_in = 1'b1;
            #1;
            check("async_rst_strand_out", int'(strand_out), 0);
            check("async_rst_request", int'(next_led_request), 0);
            check("async_rst_frame_done", int'(frame_done), 0);
            repeat (3) @(posedge clk_in);
            #1;
            rst_in = 1'b0;
        end

        target = frames_seen + 3;
        for (int c = 0; c < 3000 && frames_seen < target; c++) @(negedge clk_in);
        check("frames_after_reset", frames_seen >= target ? 1 : 0, 1);
        repeat (4) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
